// File: rtl/cp2_exc_sched.sv
// cp2_exc_sched -- exception request scheduler for the CP2 task coprocessor.
//
// Watches the time-trigger and event-trigger top-priority task indices and the
// per-task deadline warning vector. Each source's events are latched as
// pending, arbitrated by fixed priority (DL > TT > ET) and presented to the
// host CPU one at a time over a request/acknowledge handshake.
//
// Ports:
//   clk              system clock, all state updates on posedge
//   rst              asynchronous reset, active-high
//   tt_top_pri_task  top-priority ready time-trigger task (NTASK = none)
//   et_top_pri_task  top-priority ready event-trigger task (NTASK = none)
//   deadline_warn    per-task deadline reached flags
//   mask_we          write strobe for the source mask
//   mask_din         new mask bits: [0] TT, [1] ET, [2] DL; 1 = enabled
//   exc_ack          CPU acknowledge of the current exception
//   cp2_excs         any exception source enabled (OR of mask)
//   cp2_exc          exception request level
//   cp2_exccode      code of presented exception: 0 TT, 1 ET, 2 DL
//   exc_task         task index tied to the presented exception
//   pend             pending flags, same bit order as mask
//   exc_lost         sticky: a request waited TMO cycles without ack
module cp2_exc_sched #(
  parameter int unsigned NTASK  = 64,
  parameter int unsigned IDX_W  = 7,
  parameter int unsigned CODE_W = 3,
  parameter int unsigned TMO    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  tt_top_pri_task,
  input  logic [IDX_W-1:0]  et_top_pri_task,
  input  logic [NTASK-1:0]  deadline_warn,
  input  logic              mask_we,
  input  logic [2:0]        mask_din,
  input  logic              exc_ack,
  output logic              cp2_excs,
  output logic              cp2_exc,
  output logic [CODE_W-1:0] cp2_exccode,
  output logic [IDX_W-1:0]  exc_task,
  output logic [2:0]        pend,
  output logic              exc_lost
);

  localparam int unsigned CNT_W = $clog2(TMO + 1);
  localparam logic [IDX_W-1:0]  NONE    = IDX_W'(NTASK);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TMO);
  localparam logic [CODE_W-1:0] CODE_TT = CODE_W'(0);
  localparam logic [CODE_W-1:0] CODE_ET = CODE_W'(1);
  localparam logic [CODE_W-1:0] CODE_DL = CODE_W'(2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         mask_q, mask_d;
  logic [2:0]         pend_q, pend_d;
  logic [IDX_W-1:0]   prev_tt_q, prev_et_q;
  logic [NTASK-1:0]   prev_dl_q;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [IDX_W-1:0]   task_q, task_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lost_q, lost_d;

  logic               ev_tt, ev_et, ev_dl;
  logic [2:0]         ev;
  logic [2:0]         pend_clr;
  logic [2:0]         elig;
  logic               go;
  logic [CODE_W-1:0]  sel_code;
  logic [IDX_W-1:0]   sel_task;
  logic [IDX_W-1:0]   dl_idx;
  logic               in_req;
  logic               acked;

  // Event detection: a new task appearing, or a strictly better (lower) index.
  // NONE is the largest index, so "any task" always beats "none".
  always_comb begin
    ev_tt = (tt_top_pri_task != NONE) &&
            ((prev_tt_q == NONE) || (tt_top_pri_task < prev_tt_q));
    ev_et = (et_top_pri_task != NONE) &&
            ((prev_et_q == NONE) || (et_top_pri_task < prev_et_q));
    ev_dl = |(deadline_warn & ~prev_dl_q);
    ev    = {ev_dl, ev_et, ev_tt};
  end

  // Lowest set deadline index; scanned high to low so the lowest hit wins.
  always_comb begin
    dl_idx = NONE;
    for (int unsigned i = NTASK; i > 0; i--) begin
      if (deadline_warn[i-1]) dl_idx = IDX_W'(i - 1);
    end
  end

  // Fixed-priority arbitration among enabled pending sources.
  always_comb begin
    elig     = pend_q & mask_q;
    go       = |elig;
    sel_code = CODE_TT;
    sel_task = tt_top_pri_task;
    if (elig[2]) begin
      sel_code = CODE_DL;
      sel_task = dl_idx;
    end else if (elig[0]) begin
      sel_code = CODE_TT;
      sel_task = tt_top_pri_task;
    end else if (elig[1]) begin
      sel_code = CODE_ET;
      sel_task = et_top_pri_task;
    end
  end

  always_comb begin
    in_req = (state_q == S_REQ);
    acked  = in_req && exc_ack;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go)      state_d = S_REQ;
      S_REQ:   if (exc_ack) state_d = S_GAP;
      S_GAP:                state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cp2_exc     = in_req;
    cp2_excs    = |mask_q;
    cp2_exccode = code_q;
    exc_task    = task_q;
    pend        = pend_q;
    exc_lost    = lost_q;
  end

  // Datapath next-state. On ack the presented source is cleared, but a
  // same-cycle event for that source re-sets it (set wins).
  always_comb begin
    pend_clr = '0;
    if (acked) pend_clr = 3'b001 << code_q[1:0];
    pend_d = (pend_q & ~pend_clr) | ev;

    mask_d = mask_we ? mask_din : mask_q;

    code_d = code_q;
    task_d = task_q;
    if ((state_q == S_IDLE) && go) begin
      code_d = sel_code;
      task_d = sel_task;
    end

    // Counter saturates at TMO; lost sets only on the transition into TMO so
    // a mask write clears it for good while the same request stays up.
    cnt_d  = cnt_q;
    lost_d = lost_q;
    if (mask_we) lost_d = 1'b0;
    if ((state_q == S_IDLE) && go) begin
      cnt_d = '0;
    end else if (in_req && !exc_ack && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_MAX) lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q    <= 3'b001;
      pend_q    <= '0;
      prev_tt_q <= NONE;
      prev_et_q <= NONE;
      prev_dl_q <= '0;
      code_q    <= '0;
      task_q    <= NONE;
      cnt_q     <= '0;
      lost_q    <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      prev_tt_q <= tt_top_pri_task;
      prev_et_q <= et_top_pri_task;
      prev_dl_q <= deadline_warn;
      code_q    <= code_d;
      task_q    <= task_d;
      cnt_q     <= cnt_d;
      lost_q    <= lost_d;
    end
  end

endmodule

// File: doc/cp2_exc_sched.md
Name: cp2_exc_sched

Overview:
- Exception request scheduler for the CP2 task coprocessor.
- Watches three sources:
  - the time-trigger top-priority task index;
  - the event-trigger top-priority task index;
  - the per-task deadline warning vector.
- Latches each source's events as pending, arbitrates them by fixed priority, and presents one exception at a time to the host CPU with a request/acknowledge handshake.
- Sits between the task-table block and the CPU exception interface.
- Replaces the simple empty-to-non-empty edge detector for the time-trigger queue.

Parameters:
- NTASK, 64, number of task slots; index value NTASK means "no task".
- IDX_W, 7, width of task index buses; must hold 0..NTASK.
- CODE_W, 3, exception code width.
- TMO, 1023, number of cycles without ack before the lost flag sets.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- tt_top_pri_task  in  IDX_W  top-priority ready time-trigger task; NTASK = none.
- et_top_pri_task  in  IDX_W  top-priority ready event-trigger task; NTASK = none.
- deadline_warn  in  NTASK  per-task deadline reached flags.
- mask_we  in  1  write strobe for mask register.
- mask_din  in  3  new mask bits: [0] TT, [1] ET, [2] DL; 1 = enabled.
- exc_ack  in  1  CPU acknowledge of the current exception.
- cp2_excs  out  1  exception source enabled; equals OR of mask.
- cp2_exc  out  1  exception request level.
- cp2_exccode  out  CODE_W  code of presented exception: 0 TT, 1 ET, 2 DL.
- exc_task  out  IDX_W  task index tied to presented exception.
- pend  out  3  pending flags, same bit order as mask.
- exc_lost  out  1  sticky: a request waited TMO cycles without ack.

Behaviour:
- Reset values:
  - mask = 3'b001; cp2_excs = 1.
  - cp2_exc = 0; cp2_exccode = 0; exc_task = NTASK.
  - pend = 0; exc_lost = 0; state = IDLE.
  - Registered previous values: prev_tt = NTASK, prev_et = NTASK, prev_dl = 0.
  - Timeout counter = 0.
- Event detection is registered. Each cycle prev_* is updated from the inputs.
  - TT event: tt != NTASK and (prev_tt == NTASK or tt < prev_tt). Same rule for ET.
  - DL event: (deadline_warn & ~prev_dl) != 0.
- Pending:
  - An event sets its pend bit on the next edge regardless of mask; masked sources still accumulate.
  - Clear and set in the same cycle: set wins.
- Mask write:
  - mask <= mask_din on the edge where mask_we = 1.
  - The same write clears exc_lost.
  - Masking the source currently presented does not withdraw the request.
- FSM states are IDLE, REQ and GAP.
- IDLE:
  - If (pend & mask) != 0, pick DL > TT > ET.
  - Latch cp2_exccode and exc_task. For TT/ET, exc_task = the current top_pri input. For DL, exc_task = the lowest set index of deadline_warn, or NTASK if none is set now.
  - Set cp2_exc = 1, clear the counter, go to REQ.
  - Latency: an input event at edge n sets pend at n+1, and cp2_exc rises at n+2.
- REQ:
  - cp2_exc held high; code and task held stable.
  - On exc_ack = 1: clear the presented source's pend bit (subject to set-wins), drop cp2_exc, go to GAP.
  - Otherwise the counter increments, saturating at TMO. On reaching TMO, exc_lost is set; the request stays up.
- GAP: one cycle with cp2_exc = 0 (guaranteed deassertion), then IDLE.
  - Back-to-back exceptions are therefore at least 2 cycles apart: REQ, GAP, IDLE arbitrate, REQ.
- exc_ack outside REQ is ignored.
- Async reset mid-request drops cp2_exc immediately and discards all pending state.
- Index compare is unsigned IDX_W. NTASK is the largest value, so "any task" beats "none".

Test Plan:
1. Reset, then tt_top_pri_task goes 64→5 at cycle 10 → pend[0] = 1 at cycle 11; cp2_exc = 1, cp2_exccode = 0, exc_task = 5 at cycle 12. Ack → cp2_exc = 0 next edge, pend = 0.
2. With mask = 3'b111, set deadline_warn bits 9 and 3 together with tt 64→7 in the same cycle → DL presented first (code 2, task 3). Ack → one GAP cycle with cp2_exc = 0 → TT presented (code 0, task 7).
3. With mask = 3'b001, et 64→12 → pend[1] = 1 and cp2_exc stays 0. Write mask = 3'b010 → request with code 1, task 12.
4. tt goes 20→4 while a TT request is in REQ, and ack arrives in that same cycle → pend[0] stays 1 (set wins) → a second TT request, task 4, follows after GAP.
5. Hold a request without ack for TMO cycles → exc_lost = 1 at cycle TMO and cp2_exc still 1. A mask write clears exc_lost. A later ack completes the handshake normally.
6. Assert rst while in REQ with pend = 3'b111 → all outputs take their reset values asynchronously. After release, no request appears until a fresh event.
